// File: rtl/calc_pkg.sv
// Shared types and the saturate/wrap helper for the calculator core.
package calc_pkg;
    localparam int unsigned MAX_W = 16;
    localparam int unsigned DW    = 2 * MAX_W;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DIV  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } sat_t;

    // Fit a wide signed value into w bits: clamp when sat=1, else keep the low w bits.
    function automatic sat_t sat_w(input logic signed [DW-1:0] x, input int unsigned w,
                                   input logic sat);
        longint hi;
        longint lo;
        sat_t   r;
        hi    = (longint'(1) <<< (w - 1)) - longint'(1);
        lo    = -hi - longint'(1);
        r.ovf = 1'b0;
        r.val = x[MAX_W-1:0];
        if (longint'(x) > hi) begin
            r.ovf = 1'b1;
            if (sat) r.val = MAX_W'(hi);
        end else if (longint'(x) < lo) begin
            r.ovf = 1'b1;
            if (sat) r.val = MAX_W'(lo);
        end
        return r;
    endfunction
endpackage

// File: rtl/calc_divider.sv
// Signed restoring divider: one quotient bit per cycle, W cycles, truncates toward zero.
module calc_divider
    import calc_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic         ovf
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dmag;
    logic          neg_q;
    logic [CW-1:0] cnt;

    logic [W-1:0]  dvd_mag;
    logic [W-1:0]  dvs_mag;
    logic [W-1:0]  src_rem;
    logic [W-1:0]  src_quo;
    logic [W-1:0]  src_div;
    logic [W:0]    shl;
    logic [W:0]    trial;
    logic          qbit;
    logic [W-1:0]  rem_n;
    logic [W-1:0]  quo_n;
    logic [W-1:0]  q_final;

    // One restoring step; the start cycle already retires the first quotient bit.
    always_comb begin
        dvd_mag = dividend[W-1] ? W'(-dividend) : dividend;
        dvs_mag = divisor[W-1]  ? W'(-divisor)  : divisor;
        src_rem = start ? '0 : rem;
        src_quo = start ? dvd_mag : quo;
        src_div = start ? dvs_mag : dmag;
        shl     = {src_rem, src_quo[W-1]};
        trial   = shl - {1'b0, src_div};
        qbit    = ~trial[W];
        rem_n   = qbit ? trial[W-1:0] : shl[W-1:0];
        quo_n   = {src_quo[W-2:0], qbit};
        q_final = neg_q ? W'(-quo_n) : quo_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            ovf      <= 1'b0;
        end else if (abort) begin
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= rem_n;
                quo   <= quo_n;
                dmag  <= dvs_mag;
                neg_q <= dividend[W-1] ^ divisor[W-1];
                cnt   <= CW'(W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= q_final;
                    // Only most-negative / -1 yields a positive magnitude of 2^(W-1).
                    ovf      <= ~neg_q & quo_n[W-1];
                end
            end
        end
    end
endmodule

// File: rtl/calc_core.sv
// Chained signed arithmetic core: entry register, accumulator and pending operator.
module calc_core
    import calc_pkg::*;
#(
    parameter int unsigned W   = 10,
    parameter bit          SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         num_valid,
    input  logic [W-1:0] num_in,
    input  logic         op_valid,
    input  logic [2:0]   op_in,
    input  logic         neg_pulse,
    input  logic         clr_pulse,
    output logic [W-1:0] disp_val,
    output logic         disp_is_acc,
    output logic         busy,
    output logic         ovf,
    output logic         err
);
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    state_t state, state_n;
    op_t    pend, pend_n;
    op_t    cur, cur_n;
    logic [W-1:0] ent, ent_n;
    logic [W-1:0] acc, acc_n;
    logic [W-1:0] op_a, op_a_n;
    logic [W-1:0] op_b, op_b_n;
    logic [W-1:0] disp_n;
    logic         dia_n, busy_n, ovf_n, err_n;

    logic signed [DW-1:0] a_x, b_x, wide;
    sat_t         res;
    logic [W:0]   nres;
    logic         div_start, div_abort, div_busy, div_done, div_ovf;
    logic [W-1:0] div_q;

    // Negation with the most-negative corner case; bit W flags overflow.
    function automatic logic [W:0] negate(input logic [W-1:0] v);
        if (v == MIN_V) return {1'b1, (SAT ? MAX_V : MIN_V)};
        return {1'b0, W'(-v)};
    endfunction

    calc_divider #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (op_a),
        .divisor  (op_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .ovf      (div_ovf)
    );

    // Single-cycle datapath for ADD/SUB/MUL evaluated at double width.
    always_comb begin
        a_x = DW'($signed(op_a));
        b_x = DW'($signed(op_b));
        case (cur)
            OP_ADD:  wide = a_x + b_x;
            OP_SUB:  wide = a_x - b_x;
            OP_MUL:  wide = a_x * b_x;
            default: wide = '0;
        endcase
        res = sat_w(wide, W, SAT);
    end

    // Next-state and register-update logic.
    always_comb begin
        state_n   = state;
        pend_n    = pend;
        cur_n     = cur;
        ent_n     = ent;
        acc_n     = acc;
        op_a_n    = op_a;
        op_b_n    = op_b;
        dia_n     = disp_is_acc;
        busy_n    = busy;
        ovf_n     = ovf;
        err_n     = err;
        nres      = '0;
        div_start = 1'b0;
        div_abort = clr_pulse;

        case (state)
            S_IDLE: begin
                if (num_valid) begin
                    ent_n = num_in;
                    dia_n = 1'b0;
                    ovf_n = 1'b0;
                end
                if (neg_pulse) begin
                    nres = negate(dia_n ? acc_n : ent_n);
                    if (dia_n) acc_n = nres[W-1:0];
                    else       ent_n = nres[W-1:0];
                    if (nres[W]) ovf_n = 1'b1;
                end
                if (op_valid && (op_in <= 3'd4)) begin
                    op_a_n  = acc_n;
                    op_b_n  = ent_n;
                    cur_n   = pend;
                    pend_n  = op_t'(op_in);
                    ovf_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_EVAL;
                end
            end
            S_EVAL: begin
                dia_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
                case (cur)
                    OP_EQ: acc_n = op_b;
                    OP_ADD, OP_SUB, OP_MUL: begin
                        acc_n = W'(res.val);
                        ovf_n = res.ovf;
                    end
                    OP_DIV: begin
                        dia_n = disp_is_acc;
                        if (op_b == '0) begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            div_start = 1'b1;
                            busy_n    = 1'b1;
                            state_n   = S_DIV;
                        end
                    end
                    default: ;
                endcase
            end
            S_DIV: begin
                if (div_done) begin
                    acc_n   = (div_ovf && SAT) ? MAX_V : div_q;
                    ovf_n   = div_ovf;
                    dia_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (!div_busy) begin
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_ERR: ;
            default: state_n = S_IDLE;
        endcase

        if (clr_pulse) begin
            state_n = S_IDLE;
            pend_n  = OP_EQ;
            cur_n   = OP_EQ;
            ent_n   = '0;
            acc_n   = '0;
            op_a_n  = '0;
            op_b_n  = '0;
            dia_n   = 1'b0;
            busy_n  = 1'b0;
            ovf_n   = 1'b0;
            err_n   = 1'b0;
        end

        disp_n = (state_n == S_ERR) ? '0 : (dia_n ? acc_n : ent_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pend        <= OP_EQ;
            cur         <= OP_EQ;
            ent         <= '0;
            acc         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            disp_val    <= '0;
            disp_is_acc <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            cur         <= cur_n;
            ent         <= ent_n;
            acc         <= acc_n;
            op_a        <= op_a_n;
            op_b        <= op_b_n;
            disp_val    <= disp_n;
            disp_is_acc <= dia_n;
            busy        <= busy_n;
            ovf         <= ovf_n;
            err         <= err_n;
        end
    end
endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core: vector table, directed corner sequences and a random run against a model.
module tb_calc_core;
    localparam int unsigned W = 10;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic num_valid = 1'b0, op_valid = 1'b0, neg_pulse = 1'b0, clr_pulse = 1'b0;
    logic [W-1:0] num_in = '0;
    logic [2:0]   op_in = '0;
    logic signed [W-1:0] disp_val, w_disp;
    logic disp_is_acc, busy, ovf, err;
    logic w_dia, w_busy, w_ovf, w_err;

    int n_vec = 0;
    int n_bad = 0;

    calc_core #(.W(W), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .num_valid(num_valid), .num_in(num_in),
        .op_valid(op_valid), .op_in(op_in), .neg_pulse(neg_pulse), .clr_pulse(clr_pulse),
        .disp_val(disp_val), .disp_is_acc(disp_is_acc), .busy(busy), .ovf(ovf), .err(err)
    );

    calc_core #(.W(W), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .num_valid(num_valid), .num_in(num_in),
        .op_valid(op_valid), .op_in(op_in), .neg_pulse(neg_pulse), .clr_pulse(clr_pulse),
        .disp_val(w_disp), .disp_is_acc(w_dia), .busy(w_busy), .ovf(w_ovf), .err(w_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic nv; int num; logic ov; logic [2:0] op; logic ng; logic cl;
        int ed; logic ea; logic eb; logic eo; logic ee;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic nv, input int num, input logic ov, input int op,
                                input logic ng, input logic cl, input int ed,
                                input logic ea, input logic eb, input logic eo, input logic ee);
        vec_t v;
        v.nv = nv; v.num = num; v.ov = ov; v.op = 3'(op); v.ng = ng; v.cl = cl;
        v.ed = ed; v.ea = ea; v.eb = eb; v.eo = eo; v.ee = ee;
        return v;
    endfunction

    task automatic chk_out(input string name, input int d, input logic a, input logic b,
                           input logic o, input logic e, input int ed, input logic ea,
                           input logic eb, input logic eo, input logic ee);
        n_vec++;
        if (d != ed || a !== ea || b !== eb || o !== eo || e !== ee) begin
            n_bad++;
            $display("FAIL %s: got disp=%0d acc=%0b busy=%0b ovf=%0b err=%0b, expected disp=%0d acc=%0b busy=%0b ovf=%0b err=%0b",
                     name, d, a, b, o, e, ed, ea, eb, eo, ee);
        end
    endtask

    task automatic chk_main(input string name, input int ed, input logic ea, input logic eb,
                            input logic eo, input logic ee);
        chk_out(name, int'(disp_val), disp_is_acc, busy, ovf, err, ed, ea, eb, eo, ee);
    endtask

    // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic nv, input int num, input logic ov, input int op,
                         input logic ng, input logic cl);
        @(negedge clk);
        num_valid = nv; num_in = W'(num); op_valid = ov; op_in = 3'(op);
        neg_pulse = ng; clr_pulse = cl;
        @(posedge clk);
        #1;
        num_valid = 1'b0; op_valid = 1'b0; neg_pulse = 1'b0; clr_pulse = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Reference model: transaction level, result computed at acceptance and released after its latency.
    int m_ent, m_acc, m_pend, m_res, m_cnt;
    bit m_dia, m_ovf, m_err, m_busy, m_res_ovf, m_res_err;

    function automatic void fit(input longint r, output int v, output bit o);
        longint span;
        longint m;
        span = longint'(1) << W;
        o = (r > MAXV) || (r < MINV);
        if (!o) v = int'(r);
        else v = (r > MAXV) ? MAXV : MINV;
        m = ((r % span) + span) % span;
        if (m > MAXV) m = m - span;
        if (o && 0) v = int'(m);
    endfunction

    task automatic model_reset();
        m_ent = 0; m_acc = 0; m_pend = 0; m_res = 0; m_cnt = 0;
        m_dia = 0; m_ovf = 0; m_err = 0; m_busy = 0; m_res_ovf = 0; m_res_err = 0;
    endtask

    task automatic model_step(input bit nv, input int num, input bit ov, input int op,
                              input bit ng, input bit cl);
        int t;
        longint a, b;
        if (cl) begin
            model_reset();
        end else if (m_err) begin
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0;
                if (m_res_err) m_err = 1;
                else begin
                    m_acc = m_res; m_ovf = m_res_ovf; m_dia = 1;
                end
            end
        end else begin
            if (nv) begin m_ent = num; m_dia = 0; m_ovf = 0; end
            if (ng) begin
                t = m_dia ? m_acc : m_ent;
                if (t == MINV) begin t = MAXV; m_ovf = 1; end
                else t = -t;
                if (m_dia) m_acc = t; else m_ent = t;
            end
            if (ov && op <= 4) begin
                a = m_acc; b = m_ent;
                m_res_err = 0; m_res_ovf = 0; m_cnt = 1;
                case (m_pend)
                    1: fit(a + b, m_res, m_res_ovf);
                    2: fit(a - b, m_res, m_res_ovf);
                    3: fit(a * b, m_res, m_res_ovf);
                    4: begin
                        if (b == 0) m_res_err = 1;
                        else begin fit(a / b, m_res, m_res_ovf); m_cnt = W + 1; end
                    end
                    default: m_res = int'(b);
                endcase
                m_pend = op; m_ovf = 0; m_busy = 1;
            end
        end
    endtask

    int r_num, r_op, busy_cycles, guard;
    bit r_nv, r_ov, r_ng, r_cl, stale;

    initial begin
        // Reset state while rst is held
        @(posedge clk); @(posedge clk); #1;
        chk_main("reset", 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;

        // Table: nv num ov op ng cl | disp acc busy ovf err
        tbl.push_back(mk(0,    0, 0, 0, 0, 1,    0, 0, 0, 0, 0));
        tbl.push_back(mk(1,    7, 0, 0, 0, 0,    7, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 1, 0, 0,    7, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,    7, 1, 0, 0, 0));
        tbl.push_back(mk(1,    5, 0, 0, 0, 0,    5, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 0, 0, 0,    5, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,   12, 1, 0, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 1, 0,  -12, 1, 0, 0, 0));
        tbl.push_back(mk(1,    4, 0, 0, 0, 0,    4, 0, 0, 0, 0));
        tbl.push_back(mk(1,    6, 1, 2, 1, 0,   -6, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,   -6, 1, 0, 0, 0));
        tbl.push_back(mk(1,    1, 0, 0, 0, 0,    1, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 0, 0, 0,    1, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,   -7, 1, 0, 0, 0));
        tbl.push_back(mk(1,  500, 0, 0, 0, 0,  500, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,  500, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,  500, 1, 0, 0, 0));
        tbl.push_back(mk(1,    3, 0, 0, 0, 0,    3, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 0, 0, 0,    3, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,  511, 1, 0, 1, 0));
        tbl.push_back(mk(1,    2, 0, 0, 0, 0,    2, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 1, 0, 0,    2, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,    2, 1, 0, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 1, 0,   -2, 1, 0, 0, 0));
        tbl.push_back(mk(1, -512, 0, 0, 1, 0,  511, 0, 0, 1, 0));
        tbl.push_back(mk(0,    0, 1, 5, 0, 0,  511, 0, 0, 1, 0));
        tbl.push_back(mk(0,    0, 1, 2, 0, 0,  511, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,  509, 1, 0, 0, 0));
        tbl.push_back(mk(1, -100, 1, 7, 1, 0,  100, 0, 0, 0, 0));
        tbl.push_back(mk(0,    0, 1, 4, 0, 0,  100, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0, 0, 0, 0, 0,  409, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].nv, tbl[i].num, tbl[i].ov, int'(tbl[i].op), tbl[i].ng, tbl[i].cl);
            chk_main($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ea, tbl[i].eb, tbl[i].eo, tbl[i].ee);
        end

        // Overflowing multiply: saturating and wrapping instances side by side
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 500, 0, 0, 0, 0); drive(0, 0, 1, 3, 0, 0); idle();
        drive(1, 3, 0, 0, 0, 0);   drive(0, 0, 1, 0, 0, 0); idle();
        chk_main("mul_sat", 511, 1, 0, 1, 0);
        chk_out("mul_wrap", int'(w_disp), w_dia, w_busy, w_ovf, w_err, 476, 1, 0, 1, 0);

        // Signed divide latency, then divide by zero lock-up and clear
        drive(0, 0, 0, 0, 0, 1);
        drive(1, -17, 0, 0, 0, 0); drive(0, 0, 1, 4, 0, 0); idle();
        drive(1, 5, 0, 0, 0, 0);   drive(0, 0, 1, 0, 0, 0);
        busy_cycles = 0; guard = 0; stale = 0;
        while (busy && guard < 40) begin
            busy_cycles++;
            if (disp_val != 5 || disp_is_acc) stale = 1;
            idle();
            guard++;
        end
        n_vec++;
        if (guard >= 40) begin
            n_bad++;
            $display("FAIL div_busy_timeout: busy still high after %0d cycles", guard);
        end else if (busy_cycles != W + 1 || stale) begin
            n_bad++;
            $display("FAIL div_busy_len: got %0d busy cycles (early result %0b), expected %0d",
                     busy_cycles, stale, W + 1);
        end
        chk_main("div_result", -3, 1, 0, 0, 0);
        drive(1, 9, 0, 0, 0, 0); drive(0, 0, 1, 4, 0, 0); idle();
        drive(1, 0, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0); idle();
        chk_main("div_zero", 0, 0, 0, 0, 1);
        drive(1, 3, 0, 0, 0, 0);
        chk_main("err_locked_num", 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 0);
        chk_main("err_locked_op", 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk_main("err_clear", 0, 0, 0, 0, 0);

        // Clear in the middle of a division
        drive(1, 100, 0, 0, 0, 0); drive(0, 0, 1, 4, 0, 0); idle();
        drive(1, 7, 0, 0, 0, 0);   drive(0, 0, 1, 0, 0, 0);
        idle(); idle(); idle(); idle();
        drive(0, 0, 0, 0, 0, 1);
        chk_main("div_abort", 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(W) + 4; i++) begin
            idle();
            chk_main($sformatf("div_abort_quiet%0d", i), 0, 0, 0, 0, 0);
        end

        // Asynchronous reset while in EVAL, then an operator dropped while busy
        drive(1, 3, 0, 0, 0, 0); drive(0, 0, 1, 1, 0, 0);
        #1 rst = 1'b1;
        #1 chk_main("async_rst", 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        drive(1, 7, 0, 0, 0, 0); drive(0, 0, 1, 1, 0, 0);
        drive(1, 9, 1, 0, 0, 0);
        chk_main("busy_drop", 7, 1, 0, 0, 0);
        idle();
        chk_main("busy_drop_hold", 7, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0); idle();
        chk_main("busy_drop_pend", 8, 1, 0, 0, 0);

        // Random run against the model
        drive(0, 0, 0, 0, 0, 1);
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            r_nv = ($urandom % 100) < 30;
            case ($urandom % 8)
                0: r_num = 0;
                1: r_num = MINV;
                2: r_num = MAXV;
                3: r_num = -1;
                default: r_num = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            endcase
            r_ov = ($urandom % 100) < 25;
            r_op = (($urandom % 10) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            r_ng = ($urandom % 100) < 10;
            r_cl = ($urandom % 100) < 2;
            drive(r_nv, r_num, r_ov, r_op, r_ng, r_cl);
            model_step(r_nv, r_num, r_ov, r_op, r_ng, r_cl);
            chk_main($sformatf("rand%0d", i), m_err ? 0 : (m_dia ? m_acc : m_ent),
                     m_dia, m_busy, m_ovf, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
